// File: rtl/neotang_sdram_pkg.sv
// Shared types and sizes for the two-port SDRAM arbiter.
//   ADDR_W / DATA_W : backend word address and data widths
//   arb_state_t     : arbiter FSM states
//   port_id_t       : client port identifiers
//   req_slot_t      : one captured client request {addr, we, din}
package neotang_sdram_pkg;

   localparam int unsigned ADDR_W = 25;
   localparam int unsigned DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_id_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [DATA_W-1:0] din;
   } req_slot_t;

   // Round-robin helper: the port that was not served last.
   function automatic port_id_t other_port(input port_id_t p);
      return (p == PORT_A) ? PORT_B : PORT_A;
   endfunction

endpackage

// File: rtl/sdram_port_req_det.sv
// Per-port request detector with a one-deep pending slot.
//   clk_sys, reset_n            : clock, synchronous active-low reset
//   addr, oe, we, din           : client strobes, address and write data
//   clear                       : arbiter grant for this port, empties the slot
//   pending                     : slot holds an ungranted request
//   slot_addr, slot_we, slot_din: captured request (oe+we together counts as write)
module sdram_port_req_det
   import neotang_sdram_pkg::*;
(
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic              oe,
   input  logic              we,
   input  logic [DATA_W-1:0] din,
   input  logic              clear,
   output logic              pending,
   output logic [ADDR_W-1:0] slot_addr,
   output logic              slot_we,
   output logic [DATA_W-1:0] slot_din
);

   logic              act_c;
   logic              new_req_c;
   logic              prev_act;
   logic [ADDR_W-1:0] prev_addr;
   req_slot_t         slot;

   // A request is new on a strobe rising edge or an address change under a held strobe.
   assign act_c     = oe | we;
   assign new_req_c = act_c & (~prev_act | (addr != prev_addr));

   // History and slot; a fresh detection wins over a same-cycle grant so it is not lost.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         prev_act  <= 1'b0;
         prev_addr <= '0;
         pending   <= 1'b0;
         slot      <= '0;
      end else begin
         prev_act  <= act_c;
         prev_addr <= addr;
         if (new_req_c) begin
            pending <= 1'b1;
            slot    <= '{addr: addr, we: we, din: din};
         end else if (clear) begin
            pending <= 1'b0;
         end
      end
   end

   assign slot_addr = slot.addr;
   assign slot_we   = slot.we;
   assign slot_din  = slot.din;

endmodule

// File: rtl/sdram_port_arb.sv
// Two-port round-robin arbiter in front of a single-request SDRAM backend.
//   clk_sys, reset_n                        : clock, synchronous active-low reset
//   a_addr/a_oe/a_we/a_din, a_dout/a_ready  : port A (P/S/M-ROM) client
//   b_addr/b_oe/b_we/b_din, b_dout/b_ready  : port B (C-ROM) client
//   mem_req/mem_we/mem_addr/mem_wdata       : backend request, held until mem_ack
//   mem_ack/mem_rdata                       : backend completion pulse and read data
module sdram_port_arb
   import neotang_sdram_pkg::*;
(
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic              a_oe,
   input  logic              a_we,
   input  logic [DATA_W-1:0] a_din,
   output logic [DATA_W-1:0] a_dout,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic              b_oe,
   input  logic              b_we,
   input  logic [DATA_W-1:0] b_din,
   output logic [DATA_W-1:0] b_dout,
   output logic              b_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        state_q, state_d;
   port_id_t          last_q, last_d;
   port_id_t          gnt_q, gnt_d;
   port_id_t          pick_c;
   req_slot_t         sel_slot_c;

   logic              pend_a, pend_b;
   logic [ADDR_W-1:0] slot_a_addr, slot_b_addr;
   logic              slot_a_we, slot_b_we;
   logic [DATA_W-1:0] slot_a_din, slot_b_din;
   logic              clr_a_c, clr_b_c;

   logic              mem_req_d, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d;
   logic              a_ready_d, b_ready_d;
   logic [DATA_W-1:0] a_dout_d, b_dout_d;

   sdram_port_req_det u_det_a (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .addr      (a_addr),
      .oe        (a_oe),
      .we        (a_we),
      .din       (a_din),
      .clear     (clr_a_c),
      .pending   (pend_a),
      .slot_addr (slot_a_addr),
      .slot_we   (slot_a_we),
      .slot_din  (slot_a_din)
   );

   sdram_port_req_det u_det_b (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .addr      (b_addr),
      .oe        (b_oe),
      .we        (b_we),
      .din       (b_din),
      .clear     (clr_b_c),
      .pending   (pend_b),
      .slot_addr (slot_b_addr),
      .slot_we   (slot_b_we),
      .slot_din  (slot_b_din)
   );

   // Round-robin pick: on a tie serve the port not served last.
   always_comb begin
      pick_c = PORT_B;
      if (pend_a && pend_b) begin
         pick_c = other_port(last_q);
      end else if (pend_a) begin
         pick_c = PORT_A;
      end
      if (pick_c == PORT_A) begin
         sel_slot_c = '{addr: slot_a_addr, we: slot_a_we, din: slot_a_din};
      end else begin
         sel_slot_c = '{addr: slot_b_addr, we: slot_b_we, din: slot_b_din};
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         last_q    <= PORT_B;
         gnt_q     <= PORT_A;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         a_ready   <= 1'b0;
         b_ready   <= 1'b0;
         a_dout    <= '0;
         b_dout    <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         gnt_q     <= gnt_d;
         mem_req   <= mem_req_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         a_ready   <= a_ready_d;
         b_ready   <= b_ready_d;
         a_dout    <= a_dout_d;
         b_dout    <= b_dout_d;
      end
   end

   // Next state and next outputs. Ready is registered on the BUSY->DONE edge so it is
   // high exactly while in DONE; DONE->IDLE adds the mandatory low cycle on mem_req.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gnt_d       = gnt_q;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      a_ready_d   = 1'b0;
      b_ready_d   = 1'b0;
      a_dout_d    = a_dout;
      b_dout_d    = b_dout;
      clr_a_c     = 1'b0;
      clr_b_c     = 1'b0;

      case (state_q)
         IDLE: begin
            if (pend_a || pend_b) begin
               state_d     = BUSY;
               gnt_d       = pick_c;
               last_d      = pick_c;
               mem_req_d   = 1'b1;
               mem_we_d    = sel_slot_c.we;
               mem_addr_d  = sel_slot_c.addr;
               mem_wdata_d = sel_slot_c.din;
               clr_a_c     = (pick_c == PORT_A);
               clr_b_c     = (pick_c == PORT_B);
            end
         end
         BUSY: begin
            if (mem_ack) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
               if (gnt_q == PORT_A) begin
                  a_ready_d = 1'b1;
                  if (!mem_we) begin
                     a_dout_d = mem_rdata;
                  end
               end else begin
                  b_ready_d = 1'b1;
                  if (!mem_we) begin
                     b_dout_d = mem_rdata;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Self-checking bench for sdram_port_arb: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model after every clock edge.
module tb_sdram_port_arb;

   logic        clk_sys;
   logic        reset_n;
   logic [24:0] a_addr, b_addr, mem_addr;
   logic        a_oe, a_we, b_oe, b_we;
   logic [15:0] a_din, b_din, a_dout, b_dout, mem_wdata, mem_rdata;
   logic        a_ready, b_ready, mem_req, mem_we, mem_ack;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: per-port strobe history and pending request, plus the
   // transaction in flight and the earliest cycle a new grant may happen.
   int          cyc;
   logic        m_act   [2];
   logic [24:0] m_prev  [2];
   logic        m_pend  [2];
   logic [24:0] m_paddr [2];
   logic        m_pwe   [2];
   logic [15:0] m_pdin  [2];
   logic        m_busy;
   int          m_port;
   int          m_last;
   int          m_grant_ok;
   logic        e_req, e_we;
   logic [24:0] e_addr;
   logic [15:0] e_wdata;
   logic        e_rdy   [2];
   logic [15:0] e_dout  [2];

   sdram_port_arb dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .a_addr    (a_addr),
      .a_oe      (a_oe),
      .a_we      (a_we),
      .a_din     (a_din),
      .a_dout    (a_dout),
      .a_ready   (a_ready),
      .b_addr    (b_addr),
      .b_oe      (b_oe),
      .b_we      (b_we),
      .b_din     (b_din),
      .b_dout    (b_dout),
      .b_ready   (b_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   initial begin
      clk_sys = 1'b0;
      forever #10 clk_sys = ~clk_sys;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Predict the effect of the coming clock edge from the inputs currently driven.
   task automatic model_step();
      logic [24:0] i_addr [2];
      logic        i_act  [2];
      logic        i_we   [2];
      logic [15:0] i_din  [2];
      int          p;
      i_addr[0] = a_addr; i_act[0] = a_oe | a_we; i_we[0] = a_we; i_din[0] = a_din;
      i_addr[1] = b_addr; i_act[1] = b_oe | b_we; i_we[1] = b_we; i_din[1] = b_din;
      cyc++;
      if (!reset_n) begin
         for (int q = 0; q < 2; q++) begin
            m_act[q] = 1'b0; m_prev[q] = '0; m_pend[q] = 1'b0;
            e_rdy[q] = 1'b0; e_dout[q] = '0;
         end
         e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
         m_busy = 1'b0; m_last = 1; m_grant_ok = cyc + 1;
         return;
      end
      e_rdy[0] = 1'b0;
      e_rdy[1] = 1'b0;
      if (m_busy) begin
         if (mem_ack) begin
            e_req  = 1'b0;
            m_busy = 1'b0;
            e_rdy[m_port] = 1'b1;
            if (!e_we) e_dout[m_port] = mem_rdata;
            m_grant_ok = cyc + 2;
         end
      end else if (cyc >= m_grant_ok && (m_pend[0] || m_pend[1])) begin
         if (m_pend[0] && m_pend[1]) p = 1 - m_last;
         else p = m_pend[0] ? 0 : 1;
         e_req   = 1'b1;
         e_addr  = m_paddr[p];
         e_we    = m_pwe[p];
         e_wdata = m_pdin[p];
         m_pend[p] = 1'b0;
         m_busy  = 1'b1;
         m_port  = p;
         m_last  = p;
      end
      for (int q = 0; q < 2; q++) begin
         if (i_act[q] && (!m_act[q] || i_addr[q] != m_prev[q])) begin
            m_pend[q]  = 1'b1;
            m_paddr[q] = i_addr[q];
            m_pwe[q]   = i_we[q];
            m_pdin[q]  = i_din[q];
         end
         m_act[q]  = i_act[q];
         m_prev[q] = i_addr[q];
      end
   endtask

   // One clock: predict, advance, compare every output against the model.
   task automatic tick();
      model_step();
      @(posedge clk_sys);
      #1;
      chk("mem_req",   32'(mem_req),   32'(e_req));
      chk("mem_we",    32'(mem_we),    32'(e_we));
      chk("mem_addr",  32'(mem_addr),  32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      chk("a_ready",   32'(a_ready),   32'(e_rdy[0]));
      chk("b_ready",   32'(b_ready),   32'(e_rdy[1]));
      chk("a_dout",    32'(a_dout),    32'(e_dout[0]));
      chk("b_dout",    32'(b_dout),    32'(e_dout[1]));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic ack(input logic [15:0] rd);
      mem_ack   = 1'b1;
      mem_rdata = rd;
      tick();
      mem_ack   = 1'b0;
   endtask

   function automatic logic [24:0] rand_addr();
      if ($urandom_range(0, 7) == 0) return 25'($urandom);
      return 25'($urandom_range(0, 3));
   endfunction

   task automatic rand_port(inout logic oe, inout logic we, inout logic [24:0] addr,
                            inout logic [15:0] din);
      case ($urandom_range(0, 8))
         4: begin oe = 1'b0; we = 1'b0; end
         5: begin oe = 1'b1; we = 1'b0; addr = rand_addr(); end
         6: begin oe = 1'b0; we = 1'b1; addr = rand_addr(); din = 16'($urandom); end
         7: begin oe = 1'b1; we = 1'b1; addr = rand_addr(); din = 16'($urandom); end
         8: addr = rand_addr();
         default: ;
      endcase
   endtask

   initial begin
      cyc = 0; m_busy = 1'b0; m_last = 1; m_port = 0; m_grant_ok = 0;
      reset_n = 1'b0;
      a_addr = '0; a_oe = 1'b0; a_we = 1'b0; a_din = '0;
      b_addr = '0; b_oe = 1'b0; b_we = 1'b0; b_din = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      do_reset();
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_dout", 32'(a_dout), 32'd0);

      // Single read with latency.
      a_oe = 1'b1; a_addr = 25'h0001234;
      tick();
      chk("rd_req_early", 32'(mem_req), 32'd0);
      tick();
      chk("rd_req", 32'(mem_req), 32'd1);
      chk("rd_addr", 32'(mem_addr), 32'h1234);
      chk("rd_we", 32'(mem_we), 32'd0);
      a_oe = 1'b0;
      tick(); tick();
      chk("rd_hold", 32'(mem_req), 32'd1);
      ack(16'hBEEF);
      chk("rd_rdy", 32'(a_ready), 32'd1);
      chk("rd_dout", 32'(a_dout), 32'hBEEF);
      chk("rd_req_drop", 32'(mem_req), 32'd0);
      tick();
      chk("rd_rdy_pulse", 32'(a_ready), 32'd0);

      // Round-robin: tie after reset goes to A; repeat raised during A's service gives B then A.
      do_reset();
      a_oe = 1'b1; a_addr = 25'h10; b_oe = 1'b1; b_addr = 25'h20;
      tick(); tick();
      chk("rr1_addr", 32'(mem_addr), 32'h10);
      a_oe = 1'b0; b_oe = 1'b0;
      tick();
      a_oe = 1'b1; b_oe = 1'b1;
      tick();
      ack(16'h1111);
      tick(); tick();
      chk("rr2_req", 32'(mem_req), 32'd1);
      chk("rr2_addr", 32'(mem_addr), 32'h20);
      ack(16'h2222);
      tick(); tick();
      chk("rr3_req", 32'(mem_req), 32'd1);
      chk("rr3_addr", 32'(mem_addr), 32'h10);
      ack(16'h3333);
      a_oe = 1'b0; b_oe = 1'b0;
      repeat (4) tick();
      chk("rr_quiet", 32'(mem_req), 32'd0);

      // Write with full-width address; dout untouched.
      b_we = 1'b1; b_addr = 25'h1FFFFFF; b_din = 16'h5A5A;
      tick(); tick();
      chk("wr_req", 32'(mem_req), 32'd1);
      chk("wr_we", 32'(mem_we), 32'd1);
      chk("wr_addr", 32'(mem_addr), 32'h1FFFFFF);
      chk("wr_wdata", 32'(mem_wdata), 32'h5A5A);
      b_we = 1'b0;
      ack(16'hDEAD);
      chk("wr_rdy", 32'(b_ready), 32'd1);
      chk("wr_dout", 32'(b_dout), 32'h2222);
      tick();

      // Overwrite of an ungranted slot while the other port is in service.
      b_oe = 1'b1; b_addr = 25'h40;
      tick(); tick();
      chk("ov_b_addr", 32'(mem_addr), 32'h40);
      a_oe = 1'b1; a_addr = 25'h100;
      tick();
      a_addr = 25'h104;
      tick();
      a_oe = 1'b0;
      tick();
      ack(16'h4444);
      tick(); tick();
      chk("ov_addr", 32'(mem_addr), 32'h104);
      chk("ov_we", 32'(mem_we), 32'd0);
      ack(16'h5555);
      chk("ov_dout", 32'(a_dout), 32'h5555);
      b_oe = 1'b0;
      repeat (4) tick();
      chk("ov_quiet", 32'(mem_req), 32'd0);

      // Reset while BUSY abandons the transaction; a late ack is ignored.
      a_oe = 1'b1; a_addr = 25'h77;
      tick(); tick();
      chk("rb_req", 32'(mem_req), 32'd1);
      a_oe = 1'b0;
      do_reset();
      chk("rb_req0", 32'(mem_req), 32'd0);
      tick();
      ack(16'h9999);
      chk("rb_ack_req", 32'(mem_req), 32'd0);
      chk("rb_ack_rdy", 32'(a_ready), 32'd0);
      chk("rb_ack_dout", 32'(a_dout), 32'd0);

      // Strobe held across reset release is seen as a new request.
      b_oe = 1'b1; b_addr = 25'h55;
      do_reset();
      tick(); tick();
      chk("hold_req", 32'(mem_req), 32'd1);
      chk("hold_addr", 32'(mem_addr), 32'h55);
      ack(16'h0F0F);
      b_oe = 1'b0;
      tick();

      // Spurious ack in IDLE, then a normal read.
      ack(16'hAAAA);
      chk("sp_rdy_a", 32'(a_ready), 32'd0);
      chk("sp_rdy_b", 32'(b_ready), 32'd0);
      chk("sp_dout_b", 32'(b_dout), 32'h0F0F);
      chk("sp_req", 32'(mem_req), 32'd0);
      a_oe = 1'b1; a_addr = 25'h333;
      tick();
      chk("sp_rd_early", 32'(mem_req), 32'd0);
      tick();
      chk("sp_rd_req", 32'(mem_req), 32'd1);
      chk("sp_rd_addr", 32'(mem_addr), 32'h333);
      ack(16'h1357);
      chk("sp_rd_rdy", 32'(a_ready), 32'd1);
      chk("sp_rd_dout", 32'(a_dout), 32'h1357);
      a_oe = 1'b0;
      tick();

      // Randomized traffic with random backend latency, spurious acks and resets.
      for (int i = 0; i < 3000; i++) begin
         reset_n = ($urandom_range(0, 299) != 0);
         rand_port(a_oe, a_we, a_addr, a_din);
         rand_port(b_oe, b_we, b_addr, b_din);
         mem_rdata = 16'($urandom);
         if (m_busy) mem_ack = ($urandom_range(0, 2) == 0);
         else        mem_ack = ($urandom_range(0, 15) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 clk_sys  in  1  system clock, 48 MHz; all logic on rising edge.
REQ-002 reset_n  in  1  synchronous, active-low reset.
REQ-003 a_addr  in  25  port A (P/S/M-ROM) word address; a_oe  in  1  read strobe; a_we  in  1  write strobe; a_din  in  16  write data.
REQ-004 a_dout  out  16  port A read data; a_ready  out  1  one-cycle completion pulse.
REQ-005 b_addr, b_oe, b_we, b_din, b_dout, b_ready: port B (C-ROM), same widths and meanings as port A.
REQ-006 mem_req  out  1  backend request, held until ack; mem_we  out  1  1=write; mem_addr  out  25; mem_wdata  out  16.
REQ-007 mem_ack  in  1  one-cycle backend completion pulse; mem_rdata  in  16  valid in the mem_ack cycle.

Function
REQ-008 Request detection per port: a new request is registered when (oe|we)=1 and either (oe|we) was 0 last cycle or addr differs from last cycle's addr.
REQ-009 oe and we both high: treated as a write.
REQ-010 Each port has a one-deep pending slot {addr, we, din}, set in the cycle after detection; a newer detection overwrites a pending slot that has not yet been granted.
REQ-011 The pending slot is cleared at grant, so a request arriving while its port is in service is held for the next grant.
REQ-012 FSM states: IDLE, BUSY, DONE.
REQ-013 IDLE: if any slot pending, grant, load mem_addr/mem_we/mem_wdata from the slot, assert mem_req next cycle, go BUSY; else stay.
REQ-014 Arbitration: round-robin. With both ports pending, grant the port not served last; with one pending, grant it.
REQ-015 BUSY: hold mem_req and mem_* stable; on mem_ack, drop mem_req, capture mem_rdata if read, go DONE.
REQ-016 DONE: pulse granted port's ready for exactly one cycle; update its dout on reads only (writes leave dout unchanged); go IDLE.
REQ-017 Latency: detection at edge N -> mem_req high from N+2; mem_ack at edge M -> ready/dout at M+1; the next grant's mem_req can assert no earlier than M+2.
REQ-018 mem_ack in IDLE or DONE is ignored, with no state or output change.
REQ-019 mem_req is never asserted in two consecutive transactions without an intervening low cycle.
REQ-020 No timeout: BUSY waits indefinitely for mem_ack.

Reset
REQ-021 When reset_n=0 at a clock edge: FSM to IDLE; mem_req, mem_we, a_ready, b_ready to 0; mem_addr, mem_wdata, a_dout, b_dout to 0; pending slots and edge/address history cleared; last-served = B, so A wins the first tie.
REQ-022 Reset while BUSY abandons the transaction: mem_req is 0 from the reset edge, no ready pulse, and a late mem_ack is ignored per REQ-018.
REQ-023 Strobes held high across reset release are detected as new requests in the first cycle after release, because history is cleared.

Structure
REQ-024 Shared package neotang_sdram_pkg holds ADDR_W=25, DATA_W=16, the FSM state enum, and the port-id enum {PORT_A, PORT_B}.
REQ-025 One sub-module, sdram_port_req_det, is instantiated once per port. It implements REQ-008..REQ-011 and exposes pending, slot fields and a clear input.

Verification
REQ-026 Single read: a_oe=1, a_addr=0x0001234 at N -> mem_req=1, mem_addr=0x0001234, mem_we=0 at N+2; mem_ack with mem_rdata=0xBEEF at M -> a_dout=0xBEEF, a_ready=1 for one cycle at M+1.
REQ-027 Simultaneous A read 0x10 and B read 0x20 after reset -> A served first, then B; repeating both again gives the order B, A.
REQ-028 Write: b_we=1, b_addr=0x1FFFFFF, b_din=0x5A5A -> mem_we=1, mem_wdata=0x5A5A, full 25-bit address; after ack b_ready pulses and b_dout is unchanged.
REQ-029 Overwrite: A requests 0x100 then 0x104 on consecutive cycles while B is in service -> exactly one A transaction, at address 0x104.
REQ-030 Reset mid-BUSY: reset_n=0 one cycle while mem_req=1, then mem_ack two cycles later -> mem_req=0 and no ready pulse.
REQ-031 Spurious mem_ack in IDLE -> dout, ready and FSM unchanged; the following normal read completes with the correct latency.
